pwm_peripheral: RTL and testbench

Consumes the five configuration registers produced by the SPI register-write stage and drives 16 output pins. Each pin is one of three things: statically low, statically high, or a shared PWM waveform. The waveform's duty cycle comes from the 8-bit duty register. The block contains a clock prescaler, a free-running 8-bit period counter, an optional duty shadow register and a registered output stage.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_peripheral.sv | 94 +++++++++
 tb/tb_pwm_peripheral.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths, duty constants and default timing for the PWM peripheral.
package pwm_pkg;

  localparam int PWM_CNT_W           = 8;
  localparam int PWM_PINS            = 16;
  localparam int PWM_CLK_DIV_DEFAULT = 1000;
  localparam int PWM_CNT_MAX_DEFAULT = 254;

  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_OFF  = 8'h00;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;

  // 0xFF stays at 100% even if the terminal count is ever raised to 255.
  function automatic logic duty_active(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-clk tick every CLK_DIV system clocks.
import pwm_pkg::*;

module pwm_prescaler #(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick = (pre == PRE_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin static/PWM driver with a shared period counter and registered pins.
// Define PWM_DUTY_SHADOW_EN to latch the duty value only at each period wrap.
import pwm_pkg::*;

module pwm_peripheral #(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
  parameter int CNT_MAX = PWM_CNT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [PWM_CNT_W-1:0] CNT_TOP = PWM_CNT_W'(CNT_MAX);

  logic                 tick;
  logic                 wrap;
  logic [PWM_CNT_W-1:0] cnt;
  logic [PWM_CNT_W-1:0] duty_eff;
  logic                 pwm_sig;
  logic [PWM_PINS-1:0]  en_out;
  logic [PWM_PINS-1:0]  en_pwm;
  logic [PWM_PINS-1:0]  out_next;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign wrap = tick && (cnt == CNT_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + PWM_CNT_W'(1);
      end
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [PWM_CNT_W-1:0] duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= PWM_DUTY_OFF;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  assign pwm_sig = duty_active(cnt, duty_eff);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Disabled pins force low regardless of the PWM select bit.
  always_comb begin
    out_next = '0;
    for (int n = 0; n < PWM_PINS; n++) begin
      if (en_out[n]) begin
        out_next[n] = en_pwm[n] ? pwm_sig : 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: cycle scoreboard plus period-level duty checks.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PER     = 255 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_out_lo = 8'hFF;
  logic [7:0]  en_out_hi = 8'hFF;
  logic [7:0]  en_pwm_lo = 8'hFF;
  logic [7:0]  en_pwm_hi = 8'hFF;
  logic [7:0]  duty = 8'hFF;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  logic [15:0] exp_out;
  logic        exp_ps;

  int          m_pre;
  logic [7:0]  m_cnt;
  logic [7:0]  m_sh;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .CLK_DIV (CLK_DIV),
    .CNT_MAX (254)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  // Reference model: predicts the pin/strobe values registered at each edge.
  always @(posedge clk) begin : model
    logic [7:0]  deff;
    logic        pwm, tk, wr;
    logic [15:0] eo, ep, e;
    if (!rst_n) begin
      m_pre <= 0;
      m_cnt <= 8'd0;
      m_sh  <= 8'd0;
    end else begin
`ifdef PWM_DUTY_SHADOW_EN
      deff = m_sh;
`else
      deff = duty;
`endif
      pwm = (m_cnt < deff);
      eo  = {en_out_hi, en_out_lo};
      ep  = {en_pwm_hi, en_pwm_lo};
      for (int i = 0; i < 16; i++) begin
        if (!eo[i])      e[i] = 1'b0;
        else if (!ep[i]) e[i] = 1'b1;
        else             e[i] = pwm;
      end
      tk = (m_pre == CLK_DIV - 1);
      wr = tk && (m_cnt == 8'd254);
      exp_q.push_back({wr, e});
      if (wr) m_sh <= duty;
      if (tk) m_cnt <= wr ? 8'd0 : m_cnt + 8'd1;
      m_pre <= tk ? 0 : m_pre + 1;
    end
  end

  // Advance one clock and pop the prediction for it; empty queue yields X.
  task automatic step();
    @(negedge clk);
    if (exp_q.size() > 0) begin
      {exp_ps, exp_out} = exp_q.pop_front();
    end else begin
      exp_out = 'x;
      exp_ps  = 1'bx;
    end
  endtask

  task automatic sync_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first_ps;
    first_ps = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: out=%h ps=%b expected out=0000 ps=0", out, period_start);
      end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= PER; j++) begin
      step();
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL reset_sb: j=%0d out=%h ps=%b expected out=%h ps=%b", j, out, period_start, exp_out, exp_ps);
      end
      if (period_start === 1'b1 && first_ps == 0) first_ps = j;
    end
    total++;
    if (first_ps != PER) begin
      bad++;
      $display("FAIL reset_first_ps: first strobe at clk %0d expected %0d", first_ps, PER);
    end
  endtask

  task automatic test_static();
    int dev;
    dev = 0;
    {en_out_hi, en_out_lo} = 16'hA5A5;
    {en_pwm_hi, en_pwm_lo} = 16'h0000;
    for (int j = 1; j <= 3 * PER; j++) begin
      step();
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL static_sb: j=%0d out=%h ps=%b expected out=%h ps=%b", j, out, period_start, exp_out, exp_ps);
      end
      if (out !== 16'hA5A5) dev++;
    end
    total++;
    if (dev != 0) begin
      bad++;
      $display("FAIL static_const: %0d clks off A5A5 expected 0", dev);
    end
  endtask

  task automatic test_duty_extremes();
    logic [7:0]  dv[2];
    logic [15:0] cv;
    int dev;
    bit ok;
    dv[0] = 8'h00;
    dv[1] = 8'hFF;
    {en_out_hi, en_out_lo} = 16'hFFFF;
    {en_pwm_hi, en_pwm_lo} = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      duty = dv[k];
      cv   = (k == 0) ? 16'h0000 : 16'hFFFF;
      dev  = 0;
      sync_period(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL extremes_sync: no period_start seen got 0 expected 1");
      end
      for (int j = 1; j <= PER; j++) begin
        step();
        total++;
        if (out !== exp_out || period_start !== exp_ps) begin
          bad++;
          $display("FAIL extremes_sb: duty=%h j=%0d out=%h ps=%b expected out=%h ps=%b", duty, j, out, period_start, exp_out, exp_ps);
        end
        if (out !== cv) dev++;
      end
      total++;
      if (dev != 0) begin
        bad++;
        $display("FAIL extremes_const: duty=%h %0d clks off %h expected 0", duty, dev, cv);
      end
    end
  endtask

  task automatic test_duty_half();
    int hi, nps, last_ps;
    bit ok;
    hi = 0; nps = 0; last_ps = 0;
    {en_out_hi, en_out_lo} = 16'h0001;
    {en_pwm_hi, en_pwm_lo} = 16'h0001;
    duty = 8'h80;
    sync_period(ok);
    sync_period(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL half_sync: no period_start seen got 0 expected 1");
    end
    for (int j = 1; j <= PER; j++) begin
      step();
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL half_sb: j=%0d out=%h ps=%b expected out=%h ps=%b", j, out, period_start, exp_out, exp_ps);
      end
      if (out[0] === 1'b1) hi++;
      if (period_start === 1'b1) begin
        nps++;
        last_ps = j;
      end
    end
    total++;
    if (hi != 128 * CLK_DIV) begin
      bad++;
      $display("FAIL half_high: high clks=%0d expected %0d", hi, 128 * CLK_DIV);
    end
    total++;
    if (nps != 1 || last_ps != PER) begin
      bad++;
      $display("FAIL half_spacing: strobes=%0d at %0d expected 1 at %0d", nps, last_ps, PER);
    end
  endtask

  task automatic test_masking();
    int hi, viol;
    bit ok;
    hi = 0; viol = 0;
    {en_out_hi, en_out_lo} = 16'h00FF;
    {en_pwm_hi, en_pwm_lo} = 16'hFFFF;
    duty = 8'h40;
    sync_period(ok);
    sync_period(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mask_sync: no period_start seen got 0 expected 1");
    end
    for (int j = 1; j <= PER; j++) begin
      step();
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL mask_sb: j=%0d out=%h ps=%b expected out=%h ps=%b", j, out, period_start, exp_out, exp_ps);
      end
      if (out[15:8] !== 8'h00 || (out[7:0] !== 8'h00 && out[7:0] !== 8'hFF)) viol++;
      if (out[0] === 1'b1) hi++;
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL mask_pins: %0d bad pin patterns expected 0", viol);
    end
    total++;
    if (hi != 64 * CLK_DIV) begin
      bad++;
      $display("FAIL mask_high: high clks=%0d expected %0d", hi, 64 * CLK_DIV);
    end
  endtask

  task automatic test_shadow();
    int hi, exp_hi;
    bit ok;
    {en_out_hi, en_out_lo} = 16'h0001;
    {en_pwm_hi, en_pwm_lo} = 16'h0001;
    duty = 8'h20;
    sync_period(ok);
    sync_period(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL shadow_sync: no period_start seen got 0 expected 1");
    end
`ifdef PWM_DUTY_SHADOW_EN
    exp_hi = 32 * CLK_DIV;
`else
    exp_hi = 32 * CLK_DIV + (192 - 100) * CLK_DIV;
`endif
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      for (int j = 1; j <= PER; j++) begin
        step();
        total++;
        if (out !== exp_out || period_start !== exp_ps) begin
          bad++;
          $display("FAIL shadow_sb: p=%0d j=%0d out=%h ps=%b expected out=%h ps=%b", p, j, out, period_start, exp_out, exp_ps);
        end
        if (out[0] === 1'b1) hi++;
        if (p == 0 && j == 100 * CLK_DIV) duty = 8'hC0;
      end
      total++;
      if (hi != exp_hi) begin
        bad++;
        $display("FAIL shadow_high: period %0d high clks=%0d expected %0d", p, hi, exp_hi);
      end
      exp_hi = 192 * CLK_DIV;
    end
  endtask

  task automatic test_reset_mid();
    int first_ps;
    first_ps = 0;
    {en_out_hi, en_out_lo} = 16'hFFFF;
    {en_pwm_hi, en_pwm_lo} = 16'h0000;
    for (int j = 1; j <= 10 * CLK_DIV + 1; j++) begin
      step();
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL rmid_sb: j=%0d out=%h ps=%b expected out=%h ps=%b", j, out, period_start, exp_out, exp_ps);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL rmid_async: out=%h ps=%b expected out=0000 ps=0", out, period_start);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= PER; j++) begin
      step();
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL rmid_after_sb: j=%0d out=%h ps=%b expected out=%h ps=%b", j, out, period_start, exp_out, exp_ps);
      end
      if (period_start === 1'b1 && first_ps == 0) first_ps = j;
    end
    total++;
    if (first_ps != PER) begin
      bad++;
      $display("FAIL rmid_first_ps: first strobe at clk %0d expected %0d", first_ps, PER);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_duty_extremes();
    test_duty_half();
    test_masking();
    test_shadow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
